// File: rtl/pipe_stall_ctrl.sv
// Decode-side stall/bubble/flush/freeze sequencer for the 5-stage WISC-SP13 pipeline.
// Optional performance counters are compiled in with `define STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RegisterRs_fd,
  input  logic [REG_W-1:0] RegisterRt_fd,
  input  logic             uses_rs_fd,
  input  logic             uses_rt_fd,
  input  logic             is_branch_fd,
  input  logic             branch_taken,
  input  logic             halt_fd,
  input  logic [REG_W-1:0] RegisterRd_dx,
  input  logic             RegWrite_dx,
  input  logic             MemRead_dx,
  input  logic [REG_W-1:0] RegisterRd_xm,
  input  logic             RegWrite_xm,
  input  logic             MemRead_xm,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_bubble,
  output logic             fd_flush,
  output logic             freeze,
  output logic [1:0]       stall_cnt,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] perf_hz_cycles,
  output logic [CNT_W-1:0] perf_mem_cycles
);

  // Handshake: none; all outputs are single-cycle combinational enables that
  // the pipeline registers sample on the next rising clock edge.

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HZ_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t     state;
  state_t     stateNext;
  state_t     retState;
  state_t     retStateNext;
  state_t     effState;
  logic [1:0] stallCnt;
  logic [1:0] stallCntNext;
  logic [1:0] needStalls;
  logic       matchDx;
  logic       matchXm;
  logic       loadDx;
  logic       loadXm;
  logic       memStall;

  function automatic logic regMatch(
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs,
    input logic             usesRs,
    input logic [REG_W-1:0] rt,
    input logic             usesRt
  );
    return (rd != '0) && ((usesRs && (rd == rs)) || (usesRt && (rd == rt)));
  endfunction

  assign matchDx  = regMatch(RegisterRd_dx, RegisterRs_fd, uses_rs_fd, RegisterRt_fd, uses_rt_fd);
  assign matchXm  = regMatch(RegisterRd_xm, RegisterRs_fd, uses_rs_fd, RegisterRt_fd, uses_rt_fd);
  assign loadDx   = MemRead_dx & RegWrite_dx & matchDx;
  assign loadXm   = MemRead_xm & RegWrite_xm & matchXm;
  assign memStall = imem_stall | dmem_stall;

  // Branches resolve in decode, so they need load data one stage earlier than ALU ops.
  always_comb begin
    needStalls = 2'd0;
    if (loadDx) begin
      needStalls = is_branch_fd ? 2'd2 : 2'd1;
    end else if (is_branch_fd && loadXm) begin
      needStalls = 2'd1;
    end
  end

  // Once memory releases, MEM_WAIT behaves as the saved state for that cycle so no cycle is lost.
  assign effState = (state == MEM_WAIT) ? retState : state;

  always_comb begin
    stateNext    = state;
    retStateNext = retState;
    stallCntNext = stallCnt;
    pc_we        = 1'b0;
    fd_we        = 1'b0;
    dx_bubble    = 1'b0;
    fd_flush     = 1'b0;
    freeze       = 1'b0;
    if (rst) begin
      dx_bubble = 1'b1;
    end else begin
      case (effState)
        HALTED: begin
          dx_bubble = 1'b1;
        end
        RUN, HZ_STALL: begin
          if (memStall) begin
            freeze       = 1'b1;
            stateNext    = MEM_WAIT;
            retStateNext = effState;
          end else if (effState == HZ_STALL) begin
            dx_bubble    = 1'b1;
            stallCntNext = (stallCnt == 2'd0) ? 2'd0 : stallCnt - 2'd1;
            stateNext    = (stallCnt <= 2'd1) ? RUN : HZ_STALL;
          end else if (needStalls != 2'd0) begin
            dx_bubble    = 1'b1;
            stallCntNext = needStalls - 2'd1;
            stateNext    = (needStalls > 2'd1) ? HZ_STALL : RUN;
          end else begin
            pc_we     = 1'b1;
            fd_we     = 1'b1;
            fd_flush  = branch_taken;
            stateNext = halt_fd ? HALTED : RUN;
          end
        end
        default: begin
          stateNext    = RUN;
          retStateNext = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      retState <= RUN;
      stallCnt <= 2'd0;
    end else begin
      state    <= stateNext;
      retState <= retStateNext;
      stallCnt <= stallCntNext;
    end
  end

  assign stall_cnt = stallCnt;
  assign fsm_state = state;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] hzCycles;
  logic [CNT_W-1:0] memCycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hzCycles  <= '0;
      memCycles <= '0;
    end else begin
      if (dx_bubble && (state != HALTED) && (hzCycles != '1)) begin
        hzCycles <= hzCycles + 1'b1;
      end
      if (freeze && (memCycles != '1)) begin
        memCycles <= memCycles + 1'b1;
      end
    end
  end

  assign perf_hz_cycles  = hzCycles;
  assign perf_mem_cycles = memCycles;
`else
  assign perf_hz_cycles  = '0;
  assign perf_mem_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] RegisterRs_fd;
  logic [REG_W-1:0] RegisterRt_fd;
  logic             uses_rs_fd;
  logic             uses_rt_fd;
  logic             is_branch_fd;
  logic             branch_taken;
  logic             halt_fd;
  logic [REG_W-1:0] RegisterRd_dx;
  logic             RegWrite_dx;
  logic             MemRead_dx;
  logic [REG_W-1:0] RegisterRd_xm;
  logic             RegWrite_xm;
  logic             MemRead_xm;
  logic             imem_stall;
  logic             dmem_stall;
  logic             pc_we;
  logic             fd_we;
  logic             dx_bubble;
  logic             fd_flush;
  logic             freeze;
  logic [1:0]       stall_cnt;
  logic [1:0]       fsm_state;
  logic [CNT_W-1:0] perf_hz_cycles;
  logic [CNT_W-1:0] perf_mem_cycles;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegisterRs_fd(RegisterRs_fd), .RegisterRt_fd(RegisterRt_fd),
    .uses_rs_fd(uses_rs_fd), .uses_rt_fd(uses_rt_fd),
    .is_branch_fd(is_branch_fd), .branch_taken(branch_taken), .halt_fd(halt_fd),
    .RegisterRd_dx(RegisterRd_dx), .RegWrite_dx(RegWrite_dx), .MemRead_dx(MemRead_dx),
    .RegisterRd_xm(RegisterRd_xm), .RegWrite_xm(RegWrite_xm), .MemRead_xm(MemRead_xm),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_we(pc_we), .fd_we(fd_we), .dx_bubble(dx_bubble), .fd_flush(fd_flush),
    .freeze(freeze), .stall_cnt(stall_cnt), .fsm_state(fsm_state),
    .perf_hz_cycles(perf_hz_cycles), .perf_mem_cycles(perf_mem_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic setIdle();
    RegisterRs_fd = '0; RegisterRt_fd = '0; uses_rs_fd = 0; uses_rt_fd = 0;
    is_branch_fd = 0; branch_taken = 0; halt_fd = 0;
    RegisterRd_dx = '0; RegWrite_dx = 0; MemRead_dx = 0;
    RegisterRd_xm = '0; RegWrite_xm = 0; MemRead_xm = 0;
    imem_stall = 0; dmem_stall = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic setLoadDx(input int rd);
    RegisterRd_dx = rd[REG_W-1:0]; RegWrite_dx = 1; MemRead_dx = 1;
  endtask

  task automatic setBranchRs(input int rs, input bit taken);
    RegisterRs_fd = rs[REG_W-1:0]; uses_rs_fd = 1; is_branch_fd = 1; branch_taken = taken;
  endtask

  task automatic randomInputs();
    RegisterRs_fd = REG_W'($urandom_range(0, 3));
    RegisterRt_fd = REG_W'($urandom_range(0, 3));
    uses_rs_fd    = ($urandom_range(0, 99) < 70);
    uses_rt_fd    = ($urandom_range(0, 99) < 50);
    is_branch_fd  = ($urandom_range(0, 99) < 30);
    branch_taken  = is_branch_fd & ($urandom_range(0, 1) == 1);
    halt_fd       = ($urandom_range(0, 99) < 3);
    RegisterRd_dx = REG_W'($urandom_range(0, 3));
    RegWrite_dx   = ($urandom_range(0, 99) < 70);
    MemRead_dx    = ($urandom_range(0, 99) < 40);
    RegisterRd_xm = REG_W'($urandom_range(0, 3));
    RegWrite_xm   = ($urandom_range(0, 99) < 70);
    MemRead_xm    = ($urandom_range(0, 99) < 40);
    imem_stall    = ($urandom_range(0, 99) < 8);
    dmem_stall    = ($urandom_range(0, 99) < 8);
  endtask

  // Behavioural model: remaining hazard cycles, memory-wait flag, halted flag.
  int pend = 0;
  bit memWait = 0;
  bit halted = 0;
  int hzModel = 0;
  int memModel = 0;

  function automatic bit depends(input int rd);
    if (rd == 0) return 0;
    return (uses_rs_fd && rd == int'(RegisterRs_fd)) || (uses_rt_fd && rd == int'(RegisterRt_fd));
  endfunction

  function automatic int stallsNeeded();
    int n = 0;
    bit ldDx = MemRead_dx && RegWrite_dx && depends(int'(RegisterRd_dx));
    bit ldXm = MemRead_xm && RegWrite_xm && depends(int'(RegisterRd_xm));
    if (is_branch_fd) begin
      if (ldDx) n = 2;
      else if (ldXm) n = 1;
    end else if (ldDx) begin
      n = 1;
    end
    return n;
  endfunction

  // scoreboard compare: one entry per cycle for every output
  always @(negedge clk) begin
    int ePc, eFd, eBub, eFl, eFr, eCnt, eFsm, n;
    bit wasHalted;
    ePc = 0; eFd = 0; eBub = 0; eFl = 0; eFr = 0;
    wasHalted = halted;
    eFsm = halted ? 3 : (memWait ? 2 : (pend > 0 ? 1 : 0));
    eCnt = pend;
    if (rst) begin
      eBub = 1; eFsm = 0; eCnt = 0;
      pend = 0; memWait = 0; halted = 0;
    end else if (halted) begin
      eBub = 1;
    end else if (imem_stall || dmem_stall) begin
      eFr = 1;
      memWait = 1;
    end else begin
      memWait = 0;
      if (pend > 0) begin
        eBub = 1;
        pend--;
      end else begin
        n = stallsNeeded();
        if (n > 0) begin
          eBub = 1;
          pend = n - 1;
        end else begin
          ePc = 1; eFd = 1; eFl = branch_taken;
          if (halt_fd) halted = 1;
        end
      end
    end
    check("pc_we", pc_we, ePc);
    check("fd_we", fd_we, eFd);
    check("dx_bubble", dx_bubble, eBub);
    check("fd_flush", fd_flush, eFl);
    check("freeze", freeze, eFr);
    check("stall_cnt", stall_cnt, eCnt);
    check("fsm_state", fsm_state, eFsm);
`ifdef STALL_PERF_CNT_EN
    check("perf_hz", perf_hz_cycles, hzModel);
    check("perf_mem", perf_mem_cycles, memModel);
`else
    check("perf_hz", perf_hz_cycles, 0);
    check("perf_mem", perf_mem_cycles, 0);
`endif
    if (rst) begin
      hzModel = 0; memModel = 0;
    end else begin
      if (eBub == 1 && !wasHalted && hzModel < (1 << CNT_W) - 1) hzModel++;
      if (eFr == 1 && memModel < (1 << CNT_W) - 1) memModel++;
    end
  end

  initial begin
    rst = 1;
    setIdle();
    #2;
    check("rst pc_we", pc_we, 0);
    check("rst dx_bubble", dx_bubble, 1);
    check("rst freeze", freeze, 0);
    check("rst fsm", fsm_state, 0);
    nextCycle(); rst = 0;

    // load-use: one bubble
    nextCycle(); setLoadDx(3); RegisterRs_fd = 3; uses_rs_fd = 1;
    #2 check("lu pc_we", pc_we, 0); check("lu bubble", dx_bubble, 1); check("lu cnt", stall_cnt, 0);
    nextCycle();
    #2 check("lu resume pc_we", pc_we, 1); check("lu resume fsm", fsm_state, 0);

    // branch on load in dx: two stalls, flush withheld
    nextCycle(); setBranchRs(2, 1); setLoadDx(2);
    #2 check("bl0 flush", fd_flush, 0); check("bl0 pc_we", pc_we, 0); check("bl0 fsm", fsm_state, 0);
    nextCycle(); setBranchRs(2, 1); RegisterRd_xm = 2; RegWrite_xm = 1; MemRead_xm = 1;
    #2 check("bl1 fsm", fsm_state, 1); check("bl1 cnt", stall_cnt, 1); check("bl1 flush", fd_flush, 0);
    nextCycle(); setBranchRs(2, 1);
    #2 check("bl2 fsm", fsm_state, 0); check("bl2 cnt", stall_cnt, 0); check("bl2 flush", fd_flush, 1);

    // forwarded ALU result and R0
    nextCycle(); setBranchRs(4, 1); RegisterRd_dx = 4; RegWrite_dx = 1;
    #2 check("fwd pc_we", pc_we, 1); check("fwd flush", fd_flush, 1);
    nextCycle(); setLoadDx(0); RegisterRs_fd = 0; uses_rs_fd = 1;
    #2 check("r0 bubble", dx_bubble, 0); check("r0 pc_we", pc_we, 1);

    // memory stall during HZ_STALL
    nextCycle(); setBranchRs(2, 1); setLoadDx(2);
    for (int i = 0; i < 3; i++) begin
      nextCycle(); setBranchRs(2, 1); RegisterRd_xm = 2; RegWrite_xm = 1; MemRead_xm = 1; dmem_stall = 1;
      #2 check("mw freeze", freeze, 1); check("mw cnt", stall_cnt, 1); check("mw pc_we", pc_we, 0);
    end
    nextCycle(); setBranchRs(2, 1); RegisterRd_xm = 2; RegWrite_xm = 1; MemRead_xm = 1;
    #2 check("mw exit freeze", freeze, 0); check("mw exit bubble", dx_bubble, 1); check("mw exit fsm", fsm_state, 2);
    nextCycle(); setBranchRs(2, 1);
    #2 check("mw done fsm", fsm_state, 0); check("mw done flush", fd_flush, 1);

    // performance counters: load-use then 3 memory-stall cycles
    nextCycle(); rst = 1;
    nextCycle(); rst = 0;
    nextCycle(); setLoadDx(5); RegisterRt_fd = 5; uses_rt_fd = 1;
    for (int i = 0; i < 3; i++) begin
      nextCycle(); dmem_stall = 1;
    end
    nextCycle();
`ifdef STALL_PERF_CNT_EN
    #2 check("perf hz lit", perf_hz_cycles, 1); check("perf mem lit", perf_mem_cycles, 3);
`else
    #2 check("perf hz lit", perf_hz_cycles, 0); check("perf mem lit", perf_mem_cycles, 0);
`endif

    // halt then reset
    nextCycle(); halt_fd = 1;
    #2 check("halt entry pc_we", pc_we, 1);
    for (int i = 0; i < 4; i++) begin
      nextCycle(); dmem_stall = (i == 1);
      #2 check("halted fsm", fsm_state, 3); check("halted pc_we", pc_we, 0); check("halted freeze", freeze, 0);
    end
    nextCycle(); rst = 1;
    #2 check("rst pulse pc_we", pc_we, 0); check("rst pulse fsm", fsm_state, 0);
    nextCycle(); rst = 0;
    #2 check("post rst pc_we", pc_we, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      randomInputs();
      rst = ($urandom_range(0, 99) < 2);
    end
    nextCycle(); rst = 0;
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer-side partner of the forwarding unit: decides when forwarding cannot cover a dependency and sequences stall/bubble/flush for the 5-stage WISC-SP13 pipeline.
- Sits beside the decode stage; drives PC write enable, IF/ID hold, ID/EX bubble insertion, IF/ID flush on taken branch, and a global freeze for multi-cycle memory.
- Holds multi-cycle stall state (counter + FSM) so hazards are not re-evaluated against injected bubbles.

Parameters:
- REG_W, 3, register specifier width
- CNT_W, 16, width of optional performance counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- RegisterRs_fd  in  REG_W  Rs of instruction in decode
- RegisterRt_fd  in  REG_W  Rt of instruction in decode
- uses_rs_fd  in  1  decode instruction reads Rs
- uses_rt_fd  in  1  decode instruction reads Rt
- is_branch_fd  in  1  decode instruction is branch/jump-register (resolved in decode)
- branch_taken  in  1  decode-stage redirect taken
- halt_fd  in  1  HALT decoded
- RegisterRd_dx  in  REG_W  dest reg in ID/EX
- RegWrite_dx  in  1  ID/EX writes a register
- MemRead_dx  in  1  ID/EX is a load
- RegisterRd_xm  in  REG_W  dest reg in EX/MEM
- RegWrite_xm  in  1  EX/MEM writes a register
- MemRead_xm  in  1  EX/MEM is a load
- imem_stall  in  1  instruction memory not ready
- dmem_stall  in  1  data memory not ready
- pc_we  out  1  PC update enable
- fd_we  out  1  IF/ID write enable
- dx_bubble  out  1  load NOP into ID/EX
- fd_flush  out  1  squash IF/ID contents
- freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt  out  2  remaining hazard stall cycles
- fsm_state  out  2  RUN=0, HZ_STALL=1, MEM_WAIT=2, HALTED=3
- perf_hz_cycles  out  CNT_W  hazard stall cycles (optional)
- perf_mem_cycles  out  CNT_W  memory stall cycles (optional)

Behaviour:
- Reset (async, rst=1): state RUN, stall_cnt=0, counters 0; while rst high outputs pc_we=0, fd_we=0, dx_bubble=1, fd_flush=0, freeze=0.
- Match rule: Rd==Rs_fd with uses_rs_fd, or Rd==Rt_fd with uses_rt_fd; Rd==0 never matches.
- Stalls needed (evaluated only in RUN, no mem stall): N=1 for load-use (MemRead_dx & RegWrite_dx & match_dx, non-branch); N=2 for branch on load in dx; N=1 for branch on load in xm (MemRead_xm & RegWrite_xm & match_xm). Branch on non-load in dx/xm: N=0 (forwarded). Max over all cases.
- RUN, N>0: this cycle pc_we=0, fd_we=0, dx_bubble=1; stall_cnt<=N-1; if N-1>0 go HZ_STALL.
- HZ_STALL: same stall outputs; stall_cnt decrements; on reaching 0 return to RUN (hazard re-evaluated next cycle).
- RUN, N=0: pc_we=1, fd_we=1, dx_bubble=0; fd_flush=branch_taken.
- fd_flush is never asserted during any stall cycle (branch operands unresolved).
- imem_stall|dmem_stall in RUN/HZ_STALL: freeze=1, pc_we=0, fd_we=0, dx_bubble=0, fd_flush=0; go MEM_WAIT; stall_cnt and saved return state held. Memory stall has priority over hazard stall.
- MEM_WAIT: outputs as above while either stall high; when both low return to saved state (RUN or HZ_STALL) same cycle edge, no cycle lost.
- halt_fd in RUN with N=0 and no mem stall: enter HALTED; HALTED: pc_we=0, fd_we=0, dx_bubble=1, freeze=0 (pipeline drains); exit only by reset.
- Reset mid-stall or mid-MEM_WAIT: immediate return to RUN, stall_cnt=0.

Optional Feature:
- STALL_PERF_CNT_EN defined: perf_hz_cycles increments each cycle dx_bubble=1 outside reset/HALTED; perf_mem_cycles increments each cycle freeze=1; both saturate at 2^CNT_W-1, reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- LD R3 in dx, ADD decode Rs=3 uses_rs=1 -> one cycle pc_we=0, fd_we=0, dx_bubble=1, stall_cnt=0; next cycle pc_we=1.
- Branch Rs=2, LD R2 in dx -> two stall cycles, fsm_state 0->1->0, stall_cnt 1 then 0; no fd_flush even with branch_taken=1 until third cycle.
- ADD R4 in dx, branch Rs=4 taken -> no stall, fd_flush=1 one cycle; Rd=0 dependency -> no stall.
- dmem_stall high 3 cycles during HZ_STALL (stall_cnt=1) -> freeze=1 ×3, stall_cnt held 1, resumes HZ_STALL then RUN.
- halt_fd with no hazard -> fsm_state=3, pc_we=0 indefinitely; rst pulse -> RUN, pc_we=0 during rst, 1 after.
- With STALL_PERF_CNT_EN: load-use + 3-cycle dmem_stall -> perf_hz_cycles=1, perf_mem_cycles=3; without macro both read 0.
